// File: rtl/gcd_job_sequencer_if.sv
// Job, result and GCD-core signal bundle for gcd_job_sequencer.
// slave is the sequencer side; master is the job source, result sink and core side.
interface gcd_job_sequencer_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic             res_err;
    logic [WIDTH-1:0] core_in1;
    logic [WIDTH-1:0] core_in2;
    logic             core_go;
    logic [WIDTH-1:0] core_out;
    logic             core_done;
    logic             busy;
    logic [CW-1:0]    fifo_count;

    modport slave (
        input  in_valid, in_a, in_b, res_ready, core_out, core_done,
        output in_ready, res_valid, res_data, res_err, core_in1, core_in2, core_go,
               busy, fifo_count
    );

    modport master (
        output in_valid, in_a, in_b, res_ready, core_out, core_done,
        input  in_ready, res_valid, res_data, res_err, core_in1, core_in2, core_go,
               busy, fifo_count
    );
endinterface

// File: rtl/gcd_job_sequencer.sv
// In-order job FIFO feeding a subtract-loop GCD core; zero-operand jobs bypass the core.
// Optional watchdog on the core run phase: define GCD_SEQ_TIMEOUT_EN.
//
// state | meaning
// IDLE  | wait for a queued job, pop the FIFO head
// LOAD  | decide bypass or issue to core
// RUN   | core_go held until core_done (or watchdog expiry)
// CLR   | core_go low, wait for core_done to clear
// RESP  | result held on res_valid until res_ready
module gcd_job_sequencer #(
    parameter int WIDTH          = 32,
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input logic                clk,
    input logic                rst,
    gcd_job_sequencer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("gcd_job_sequencer: DEPTH must be a power of 2 and at least 2");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("gcd_job_sequencer: TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_CLR,
        S_RESP
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] mem_a_q [DEPTH];
    logic [WIDTH-1:0] mem_b_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] job_a_q, job_a_d, job_b_q, job_b_d;
    logic [WIDTH-1:0] in1_q, in1_d, in2_q, in2_d;
    logic [WIDTH-1:0] res_data_q, res_data_d;
    logic             go_q, go_d, res_valid_q, res_valid_d;
    logic             full, push, pop;

`ifdef GCD_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] timer_q, timer_d;
    logic          err_q, err_d;
`endif

    // Full is taken from the registered count only, so a same-cycle pop never frees a slot.
    assign full = (count_q == CW'(DEPTH));
    assign push = bus.in_valid && !full;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_a_q[wr_ptr_q] <= bus.in_a;
            mem_b_q[wr_ptr_q] <= bus.in_b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            if (push && !pop)      count_q <= count_q + CW'(1);
            else if (!push && pop) count_q <= count_q - CW'(1);
        end
    end

    always_comb begin
        state_d     = state_q;
        job_a_d     = job_a_q;
        job_b_d     = job_b_q;
        in1_d       = in1_q;
        in2_d       = in2_q;
        go_d        = go_q;
        res_data_d  = res_data_q;
        res_valid_d = res_valid_q;
        pop         = 1'b0;
`ifdef GCD_SEQ_TIMEOUT_EN
        timer_d     = timer_q;
        err_d       = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    job_a_d = mem_a_q[rd_ptr_q];
                    job_b_d = mem_b_q[rd_ptr_q];
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                // The core never terminates on a zero operand; A|B is gcd for that case.
                if ((job_a_q == '0) || (job_b_q == '0)) begin
                    res_data_d  = job_a_q | job_b_q;
                    res_valid_d = 1'b1;
                    state_d     = S_RESP;
                end else begin
                    in1_d   = job_a_q;
                    in2_d   = job_b_q;
                    go_d    = 1'b1;
                    state_d = S_RUN;
`ifdef GCD_SEQ_TIMEOUT_EN
                    timer_d = '0;
`endif
                end
            end
            S_RUN: begin
                if (bus.core_done) begin
                    res_data_d = bus.core_out;
                    go_d       = 1'b0;
                    state_d    = S_CLR;
                end
`ifdef GCD_SEQ_TIMEOUT_EN
                else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    res_data_d = '0;
                    err_d      = 1'b1;
                    go_d       = 1'b0;
                    state_d    = S_CLR;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
`endif
            end
            S_CLR: begin
                if (!bus.core_done) begin
                    res_valid_d = 1'b1;
                    state_d     = S_RESP;
                end
            end
            S_RESP: begin
                if (bus.res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = S_IDLE;
`ifdef GCD_SEQ_TIMEOUT_EN
                    err_d       = 1'b0;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            job_a_q     <= '0;
            job_b_q     <= '0;
            in1_q       <= '0;
            in2_q       <= '0;
            go_q        <= 1'b0;
            res_data_q  <= '0;
            res_valid_q <= 1'b0;
`ifdef GCD_SEQ_TIMEOUT_EN
            timer_q     <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            job_a_q     <= job_a_d;
            job_b_q     <= job_b_d;
            in1_q       <= in1_d;
            in2_q       <= in2_d;
            go_q        <= go_d;
            res_data_q  <= res_data_d;
            res_valid_q <= res_valid_d;
`ifdef GCD_SEQ_TIMEOUT_EN
            timer_q     <= timer_d;
            err_q       <= err_d;
`endif
        end
    end

    assign bus.in_ready   = !full;
    assign bus.res_valid  = res_valid_q;
    assign bus.res_data   = res_data_q;
    assign bus.core_in1   = in1_q;
    assign bus.core_in2   = in2_q;
    assign bus.core_go    = go_q;
    assign bus.busy       = (state_q != S_IDLE) || (count_q != '0);
    assign bus.fifo_count = count_q;
`ifdef GCD_SEQ_TIMEOUT_EN
    assign bus.res_err    = err_q;
`else
    assign bus.res_err    = 1'b0;
`endif
endmodule

// File: tb/tb_gcd_job_sequencer.sv
// Bench for gcd_job_sequencer with a subtract-loop core model; results checked against a Euclid reference.
// Watchdog scenario is exercised when GCD_SEQ_TIMEOUT_EN is defined.
module tb_gcd_job_sequencer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    gcd_job_sequencer_if #(.WIDTH(32), .DEPTH(4)) bus ();

    gcd_job_sequencer #(.WIDTH(32), .DEPTH(4), .TIMEOUT_CYCLES(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_data[$];
    logic        exp_err[$];
    bit          stuck = 1'b0;

    // Core model: subtract loop, done held until go drops; 'stuck' models a core that never finishes.
    logic [31:0] cx, cy;
    logic        crun;
    always_ff @(posedge clk) begin
        if (rst) begin
            crun          <= 1'b0;
            cx            <= '0;
            cy            <= '0;
            bus.core_done <= 1'b0;
            bus.core_out  <= '0;
        end else if (crun) begin
            if (cx == cy) begin
                bus.core_out  <= cx;
                bus.core_done <= 1'b1;
                crun          <= 1'b0;
            end else if (cx > cy) cx <= cx - cy;
            else                  cy <= cy - cx;
        end else if (bus.core_done) begin
            if (!bus.core_go) bus.core_done <= 1'b0;
        end else if (bus.core_go && !stuck) begin
            cx   <= bus.core_in1;
            cy   <= bus.core_in2;
            crun <= 1'b1;
        end
    end

    function automatic logic [31:0] ref_gcd(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] t;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] b, input bit aborted);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        while (!bus.in_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("push_accept_in_time", 32'(n < 3000), 32'd1);
        @(posedge clk);
        exp_data.push_back(aborted ? 32'd0 : ref_gcd(a, b));
        exp_err.push_back(aborted);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic collect_one(input int dly);
        int          n;
        logic [31:0] ed;
        logic        ee;
        n = 0;
        bus.res_ready = 1'b0;
        repeat (dly) @(negedge clk);
        bus.res_ready = 1'b1;
        while (!bus.res_valid && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("res_valid_in_time", 32'(n < 3000), 32'd1);
        if (exp_data.size() == 0) begin
            ed = 32'hFFFF_FFFF;
            ee = 1'bx;
        end else begin
            ed = exp_data.pop_front();
            ee = exp_err.pop_front();
        end
        chk("res_data", bus.res_data, ed);
        chk("res_err", 32'(bus.res_err), 32'(ee));
        @(posedge clk);
        @(negedge clk);
        bus.res_ready = 1'b0;
    endtask

    initial begin
        int n, cnt;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.res_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
        chk("rst_res_data", bus.res_data, 32'd0);
        chk("rst_res_err", 32'(bus.res_err), 32'd0);
        chk("rst_core_go", 32'(bus.core_go), 32'd0);
        chk("rst_core_in1", bus.core_in1, 32'd0);
        chk("rst_core_in2", bus.core_in2, 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_fifo_count", 32'(bus.fifo_count), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // (48,18): issue latency, operand stability while go is high, result 6
        push(32'd48, 32'd18, 1'b0);
        @(negedge clk);
        chk("issue_go_t1", 32'(bus.core_go), 32'd0);
        @(negedge clk);
        chk("issue_go_t2", 32'(bus.core_go), 32'd1);
        chk("issue_busy", 32'(bus.busy), 32'd1);
        n = 0;
        while (bus.core_go && n < 1000) begin
            chk("hold_in1", bus.core_in1, 32'd48);
            chk("hold_in2", bus.core_in2, 32'd18);
            @(negedge clk);
            n++;
        end
        chk("go_released", 32'(bus.core_go), 32'd0);
        collect_one(0);

        // zero-operand bypass: (0,35) then (0,0)
        push(32'd0, 32'd35, 1'b0);
        @(negedge clk);
        chk("bypass_valid_t1", 32'(bus.res_valid), 32'd0);
        chk("bypass_go_t1", 32'(bus.core_go), 32'd0);
        @(negedge clk);
        chk("bypass_valid_t2", 32'(bus.res_valid), 32'd1);
        chk("bypass_go_t2", 32'(bus.core_go), 32'd0);
        collect_one(0);
        push(32'd0, 32'd0, 1'b0);
        cnt = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.core_go) cnt++;
        end
        chk("bypass00_go_cycles", 32'(cnt), 32'd0);
        collect_one(0);

        // result backpressure: job waits in RESP for 10 cycles
        push(32'd20, 32'd15, 1'b0);
        n = 0;
        while (!bus.res_valid && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("bp_reach_resp", 32'(bus.res_valid), 32'd1);
        repeat (10) begin
            @(negedge clk);
            chk("bp_valid_held", 32'(bus.res_valid), 32'd1);
            chk("bp_data_held", bus.res_data, 32'd5);
            chk("bp_no_go", 32'(bus.core_go), 32'd0);
        end

        // fill the FIFO behind the stalled result; fifth job must be held off
        push(32'd12, 32'd8, 1'b0);
        push(32'd9, 32'd6, 1'b0);
        push(32'd7, 32'd5, 1'b0);
        push(32'd100, 32'd75, 1'b0);
        chk("full_count", 32'(bus.fifo_count), 32'd4);
        chk("full_in_ready", 32'(bus.in_ready), 32'd0);
        bus.in_valid = 1'b1;
        bus.in_a     = 32'd21;
        bus.in_b     = 32'd14;
        repeat (3) begin
            @(negedge clk);
            chk("held_count", 32'(bus.fifo_count), 32'd4);
            chk("held_in_ready", 32'(bus.in_ready), 32'd0);
        end
        fork
            push(32'd21, 32'd14, 1'b0);
            repeat (6) collect_one(0);
        join

        // synchronous reset while a job runs with two more queued
        push(32'd1000, 32'd1, 1'b0);
        push(32'd30, 32'd12, 1'b0);
        push(32'd40, 32'd15, 1'b0);
        chk("prerst_go", 32'(bus.core_go), 32'd1);
        chk("prerst_count", 32'(bus.fifo_count), 32'd2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_data.delete();
        exp_err.delete();
        chk("midrst_go", 32'(bus.core_go), 32'd0);
        chk("midrst_count", 32'(bus.fifo_count), 32'd0);
        chk("midrst_valid", 32'(bus.res_valid), 32'd0);
        chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("midrst_in1", bus.core_in1, 32'd0);
        cnt = 0;
        bus.res_ready = 1'b1;
        repeat (30) begin
            @(negedge clk);
            if (bus.res_valid || bus.core_go) cnt++;
        end
        bus.res_ready = 1'b0;
        chk("postrst_stale_cycles", 32'(cnt), 32'd0);
        push(32'd81, 32'd27, 1'b0);
        collect_one(0);

        // randomized jobs with random push gaps and random result backpressure
        fork
            begin
                logic [31:0] ra, rb;
                for (int i = 0; i < 24; i++) begin
                    ra = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom_range(1, 300);
                    rb = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom_range(1, 300);
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    push(ra, rb, 1'b0);
                end
            end
            begin
                for (int j = 0; j < 24; j++) collect_one($urandom_range(0, 4));
            end
        join

`ifdef GCD_SEQ_TIMEOUT_EN
        stuck = 1'b1;
        push(32'd5, 32'd3, 1'b1);
        n = 0;
        while (!bus.core_go && n < 20) begin
            @(negedge clk);
            n++;
        end
        cnt = 0;
        while (bus.core_go && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        chk("timeout_run_cycles", 32'(cnt), 32'd16);
        stuck = 1'b0;
        push(32'd9, 32'd6, 1'b0);
        collect_one(0);
        collect_one(0);
`endif

        chk("scoreboard_empty", 32'(exp_data.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
